// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command scheduler: FSM states,
// requester indices, response lengths, common command frames and the arbiter.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SEND,
    ST_NCR,
    ST_RECV,
    ST_POST,
    ST_DONE
  } sd_state_e;

  localparam int INIT = 0;
  localparam int RD   = 1;
  localparam int WR   = 2;

  localparam int R1_BITS = 8;
  localparam int R7_BITS = 40;

  localparam logic [47:0] CMD0   = 48'h400000000095;
  localparam logic [47:0] CMD8   = 48'h48000001AA87;
  localparam logic [47:0] CMD55  = 48'h770000000065;
  localparam logic [47:0] ACMD41 = 48'h694000000077;
  localparam logic [47:0] CMD17  = 48'h510000000055;

  // Init always wins; read and write share the bus by the round-robin preference.
  function automatic logic [1:0] arb_pick(input logic [2:0] req, input logic pref_wr);
    logic [1:0] win;
    win = 2'(INIT);
    if (req[INIT])
      win = 2'(INIT);
    else if (req[RD] && req[WR])
      win = pref_wr ? 2'(WR) : 2'(RD);
    else if (req[RD])
      win = 2'(RD);
    else if (req[WR])
      win = 2'(WR);
    return win;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// CRC7 (x^7 + x^3 + 1) over a W-bit word, MSB first; the serial shift
// register is unrolled so the result is ready in a single cycle.
module sd_crc7 #(
  parameter int W = 40
) (
  input  logic [W-1:0] data_i,
  output logic [6:0]   crc_o
);

  logic [6:0] crc_c;
  logic       fb_c;

  always_comb begin
    crc_c = '0;
    fb_c  = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      fb_c  = data_i[i] ^ crc_c[6];
      crc_c = {crc_c[5:0], 1'b0} ^ (fb_c ? 7'h09 : 7'h00);
    end
  end

  assign crc_o = crc_c;

endmodule

// File: rtl/sd_cmd_sched.sv
// SD SPI command scheduler: arbitrates three requesters, sends one 48-bit frame
// and collects an R1/R7 response. Define SD_CMD_CRC_EN to regenerate the frame CRC7.
module sd_cmd_sched
  import sd_cmd_pkg::*;
#(
  parameter int NCR_MAX   = 64,
  parameter int PRE_CLKS  = 8,
  parameter int POST_CLKS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req,
  input  logic [2:0][47:0] cmd_i,
  input  logic [2:0]      r7_i,
  output logic [2:0]      gnt,
  output logic            done,
  output logic            timeout,
  output logic [39:0]     resp,
  output logic            sd_cs,
  output logic            sd_mosi,
  input  logic            sd_miso
);

  localparam logic [7:0] PRE_LAST  = 8'(PRE_CLKS - 1);
  localparam logic [7:0] POST_LAST = 8'(POST_CLKS - 1);
  localparam logic [7:0] NCR_LAST  = 8'(NCR_MAX - 1);
  // The start bit is consumed in NCR, so RECV counts the remaining bits down to 0.
  localparam logic [5:0] R1_REM    = 6'(R1_BITS - 2);
  localparam logic [5:0] R7_REM    = 6'(R7_BITS - 2);

  sd_state_e   state_q, state_d;
  logic [1:0]  win;
  logic [1:0]  gnt_idx_q;
  logic [47:0] frame_q;
  logic        r7_q;
  logic [5:0]  bit_q;
  logic [7:0]  wait_q;
  logic [39:0] resp_q;
  logic        timeout_q;
  logic        pref_wr_q;

  assign win = arb_pick(req, pref_wr_q);

`ifdef SD_CMD_CRC_EN
  logic [6:0] crc;

  sd_crc7 #(.W(40)) u_crc (
    .data_i (frame_q[47:8]),
    .crc_o  (crc)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|req) state_d = ST_PRE;
      ST_PRE:  if (wait_q == PRE_LAST) state_d = ST_SEND;
      ST_SEND: if (bit_q == 6'd0) state_d = ST_NCR;
      ST_NCR: begin
        if (!sd_miso)
          state_d = ST_RECV;
        else if (wait_q == NCR_LAST)
          state_d = ST_POST;
      end
      ST_RECV: if (bit_q == 6'd0) state_d = ST_POST;
      ST_POST: if (wait_q == POST_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sd_cs   = 1'b1;
    sd_mosi = 1'b1;
    gnt     = '0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_DONE: done = 1'b1;
      default: begin
        sd_cs = 1'b0;
        gnt   = 3'b001 << gnt_idx_q;
      end
    endcase
    if (state_q == ST_SEND)
      sd_mosi = frame_q[bit_q];
  end

  assign resp    = resp_q;
  assign timeout = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx_q <= '0;
      frame_q   <= '0;
      r7_q      <= 1'b0;
      bit_q     <= '0;
      wait_q    <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
      pref_wr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_idx_q <= win;
            frame_q   <= cmd_i[win];
            r7_q      <= r7_i[win];
            timeout_q <= 1'b0;
            wait_q    <= '0;
            if (win == 2'(RD))
              pref_wr_q <= 1'b1;
            else if (win == 2'(WR))
              pref_wr_q <= 1'b0;
          end
        end
        ST_PRE: begin
          if (wait_q == PRE_LAST) begin
            wait_q <= '0;
            bit_q  <= 6'd47;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
`ifdef SD_CMD_CRC_EN
          frame_q[7:0] <= {crc, 1'b1};
`endif
        end
        ST_SEND: bit_q <= bit_q - 6'd1;
        ST_NCR: begin
          if (!sd_miso) begin
            resp_q <= '0;
            bit_q  <= r7_q ? R7_REM : R1_REM;
            wait_q <= '0;
          end else if (wait_q == NCR_LAST) begin
            timeout_q <= 1'b1;
            resp_q    <= 40'h00000000FF;
            wait_q    <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        ST_RECV: begin
          resp_q <= {resp_q[38:0], sd_miso};
          bit_q  <= bit_q - 6'd1;
        end
        ST_POST: wait_q <= wait_q + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sched.sv
// Directed bench for sd_cmd_sched: single transactions, timeout, reset abort,
// arbitration order and (with SD_CMD_CRC_EN) CRC regeneration.
module tb_sd_cmd_sched;
  import sd_cmd_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       req = 3'b000;
  logic [2:0][47:0] cmd;
  logic [2:0]       r7 = 3'b000;
  logic             miso = 1'b1;
  logic [2:0]       gnt;
  logic             done;
  logic             timeout;
  logic [39:0]      resp;
  logic             sd_cs;
  logic             sd_mosi;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sd_cmd_sched dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .cmd_i   (cmd),
    .r7_i    (r7),
    .gnt     (gnt),
    .done    (done),
    .timeout (timeout),
    .resp    (resp),
    .sd_cs   (sd_cs),
    .sd_mosi (sd_mosi),
    .sd_miso (miso)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One transaction. Cycle 1 is the first cycle with gnt high; the card replies
  // idle_ones 1s into NCR followed by rbits bits of rsp, MSB first.
  task automatic do_txn(input string tag, input logic [2:0] r, input int exp_idx,
                        input logic [47:0] exp_frame, input int idle_ones,
                        input logic [39:0] rsp, input int rbits, input int exp_cycle,
                        input logic exp_to, input logic [39:0] exp_resp, input bit hold);
    logic [47:0] cap;
    int c, done_c, k;
    bit got;
    logic [2:0] want_gnt;
    want_gnt = 3'b001 << exp_idx;
    req = r;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (gnt != 3'b000) got = 1;
    end
    chk({tag, "_gnt"}, 48'(gnt), 48'(want_gnt));
    if (!hold) req = 3'b000;
    if (!got) return;
    c = 1;
    cap = '0;
    done_c = 0;
    while (c < 400 && done_c == 0) begin
      if (c >= 57) begin
        k = c - 57;
        if (k < idle_ones) miso = 1'b1;
        else if (k - idle_ones < rbits) miso = rsp[rbits - 1 - (k - idle_ones)];
        else miso = 1'b1;
      end
      if (c >= 9 && c <= 56) cap = {cap[46:0], sd_mosi};
      if (done) done_c = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    miso = 1'b1;
    $display("txn %s: gnt=%b frame=%h done_cycle=%0d resp=%h timeout=%b",
             tag, want_gnt, cap, done_c, resp, timeout);
    chk({tag, "_frame"}, cap, exp_frame);
    chk({tag, "_done_cycle"}, 48'(done_c), 48'(exp_cycle));
    chk({tag, "_resp"}, 48'(resp), 48'(exp_resp));
    chk({tag, "_timeout"}, 48'(timeout), 48'(exp_to));
    chk({tag, "_cs_done"}, 48'(sd_cs), 48'd1);
    chk({tag, "_gnt_done"}, 48'(gnt), 48'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 48'(done), 48'd0);
    chk({tag, "_cs_idle"}, 48'(sd_cs), 48'd1);
  endtask

  initial begin
    int dcount;
    bit got;
    cmd[0] = CMD0;
    cmd[1] = CMD8;
    cmd[2] = ACMD41;

    repeat (2) @(negedge clk);
    chk("rst_cs", 48'(sd_cs), 48'd1);
    chk("rst_mosi", 48'(sd_mosi), 48'd1);
    chk("rst_gnt", 48'(gnt), 48'd0);
    chk("rst_done", 48'(done), 48'd0);
    chk("rst_timeout", 48'(timeout), 48'd0);
    chk("rst_resp", 48'(resp), 48'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cs", 48'(sd_cs), 48'd1);

    // CMD0, R1 = 0x01 after three idle bytes: 8+48+4+7+8+1
    do_txn("cmd0", 3'b001, INIT, CMD0, 3, 40'h01, 8, 76, 1'b0, 40'h01, 1'b0);

    // CMD8, R7 after one idle bit: 8+48+2+39+8+1
    r7 = 3'b010;
    do_txn("cmd8", 3'b010, RD, CMD8, 1, 40'h01000001AA, 40, 106, 1'b0, 40'h01000001AA, 1'b0);
    r7 = 3'b000;

    // No start bit: 8+48+64+8+1
    do_txn("tmo", 3'b001, INIT, CMD0, 1000, 40'h0, 0, 129, 1'b1, 40'hFF, 1'b0);

    // Reset while frame bit 20 is on the wire (cycle 9 + 47 - 20 = 36)
    req = 3'b001;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (gnt != 3'b000) got = 1;
    end
    chk("abort_gnt", 48'(gnt), 48'd1);
    req = 3'b000;
    repeat (35) @(negedge clk);
    chk("abort_bit20", 48'(sd_mosi), 48'd0);
    rst = 1'b1;
    #1;
    chk("abort_cs", 48'(sd_cs), 48'd1);
    chk("abort_mosi", 48'(sd_mosi), 48'd1);
    chk("abort_gnt0", 48'(gnt), 48'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcount++;
    end
    $display("txn abort: done pulses after reset=%0d", dcount);
    chk("abort_no_done", 48'(dcount), 48'd0);
    do_txn("after_abort", 3'b001, INIT, CMD0, 3, 40'h01, 8, 76, 1'b0, 40'h01, 1'b0);

    // Arbitration with read/write both held, then init joins: 8+48+1+7+8+1
    cmd[1] = CMD55;
    cmd[2] = ACMD41;
    do_txn("arb_rd1", 3'b110, RD, CMD55, 0, 40'h05, 8, 73, 1'b0, 40'h05, 1'b1);
    do_txn("arb_wr", 3'b110, WR, ACMD41, 0, 40'h7E, 8, 73, 1'b0, 40'h7E, 1'b1);
    do_txn("arb_rd2", 3'b110, RD, CMD55, 0, 40'h3C, 8, 73, 1'b0, 40'h3C, 1'b1);
    do_txn("arb_init", 3'b111, INIT, CMD0, 0, 40'h01, 8, 73, 1'b0, 40'h01, 1'b0);

`ifdef SD_CMD_CRC_EN
    cmd[0] = 48'h400000000000;
    do_txn("crc", 3'b001, INIT, 48'h400000000095, 0, 40'h01, 8, 73, 1'b0, 40'h01, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
